// File: rtl/tpu_ctrl.sv
// Main sequencer of the 4x4 systolic TPU: walks every output tile of C = A x B (feed, drain, write, clear).
// Optional CTRL_PERF_CNT_EN adds a saturating busy-cycle counter on perf_cycles.
module tpu_ctrl #(
   parameter int ARRAY_DIM = 4,
   parameter int ADDR_W    = 8,
   parameter int DRAIN_CYC = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        row_a,
   input  logic [3:0]        col_b,
   input  logic [3:0]        k,
   output logic              done,
   output logic              busy,
   output logic              gbuff_a_rd_en,
   output logic [ADDR_W-1:0] gbuff_a_addr,
   output logic              gbuff_b_rd_en,
   output logic [ADDR_W-1:0] gbuff_b_addr,
   output logic              pe_valid,
   output logic              pe_clr,
   output logic [1:0]        out_sel,
   output logic              gbuff_out_wr_en,
   output logic [ADDR_W-1:0] gbuff_out_addr
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [15:0]       perf_cycles
`endif
);

   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_WRITE, S_CLR, S_DONE
   } state_t;

   state_t             state, state_n;
   logic [3:0]         r_q, c_q, k_q;
   logic [3:0]         tr_q, tc_q, tr_last_q, tc_last_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [ADDR_W-1:0]  row_idx;
   logic               last_tile;

   assign last_tile = (tr_q == tr_last_q) && (tc_q == tc_last_q);
   assign row_idx   = ADDR_W'(ARRAY_DIM) * ADDR_W'(tr_q) + ADDR_W'(cnt_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         r_q       <= '0;
         c_q       <= '0;
         k_q       <= '0;
         tr_q      <= '0;
         tc_q      <= '0;
         tr_last_q <= '0;
         tc_last_q <= '0;
         cnt_q     <= '0;
         pe_valid  <= 1'b0;
      end else begin
         state    <= state_n;
         pe_valid <= gbuff_a_rd_en;
         // cnt_q is the in-state cycle index (kk in FEED, j in WRITE)
         if (state_n != state) cnt_q <= '0;
         else                  cnt_q <= cnt_q + CNT_W'(1);
         if (state == S_IDLE && start) begin
            r_q       <= row_a;
            c_q       <= col_b;
            k_q       <= k;
            tr_last_q <= 4'((row_a - 4'd1) / 4'(ARRAY_DIM));
            tc_last_q <= 4'((col_b - 4'd1) / 4'(ARRAY_DIM));
         end
         if (state == S_LOAD) begin
            tr_q <= '0;
            tc_q <= '0;
         end else if (state == S_CLR) begin
            if (tr_q == tr_last_q) begin
               tr_q <= '0;
               tc_q <= tc_q + 4'd1;
            end else begin
               tr_q <= tr_q + 4'd1;
            end
         end
      end
   end

   always_comb begin
      state_n         = state;
      done            = 1'b0;
      busy            = 1'b1;
      gbuff_a_rd_en   = 1'b0;
      gbuff_b_rd_en   = 1'b0;
      gbuff_a_addr    = '0;
      gbuff_b_addr    = '0;
      pe_clr          = 1'b0;
      out_sel         = '0;
      gbuff_out_wr_en = 1'b0;
      gbuff_out_addr  = '0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_n = S_LOAD;
         end
         S_LOAD: begin
            if (r_q == '0 || c_q == '0) state_n = S_DONE;
            else if (k_q == '0)         state_n = S_WRITE;
            else                        state_n = S_FEED;
         end
         S_FEED: begin
            gbuff_a_rd_en = 1'b1;
            gbuff_b_rd_en = 1'b1;
            gbuff_a_addr  = ADDR_W'(tr_q) * ADDR_W'(k_q) + ADDR_W'(cnt_q);
            gbuff_b_addr  = ADDR_W'(tc_q) * ADDR_W'(k_q) + ADDR_W'(cnt_q);
            if (cnt_q == CNT_W'(k_q - 4'd1)) state_n = S_DRAIN;
         end
         S_DRAIN: begin
            if (cnt_q == CNT_W'(DRAIN_CYC)) state_n = S_WRITE;
         end
         S_WRITE: begin
            out_sel         = cnt_q[1:0];
            gbuff_out_wr_en = (row_idx < ADDR_W'(r_q));
            gbuff_out_addr  = ADDR_W'(tc_q) * ADDR_W'(r_q) + row_idx;
            if (cnt_q == CNT_W'(ARRAY_DIM - 1)) state_n = S_CLR;
         end
         S_CLR: begin
            pe_clr = 1'b1;
            if (last_tile)      state_n = S_DONE;
            else if (k_q == '0) state_n = S_WRITE;
            else                state_n = S_FEED;
         end
         S_DONE: begin
            done = 1'b1;
            busy = 1'b0;
            if (!start) state_n = S_IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_n = S_IDLE;
         end
      endcase
   end

`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          perf_cycles <= '0;
      else if (state == S_LOAD)         perf_cycles <= '0;
      else if (busy && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 16'd1;
   end
`endif

endmodule

// File: tb/tb_tpu_ctrl.sv
// Bench for tpu_ctrl: per-cycle comparison against a tile-schedule model computed from R, C, K.
module tb_tpu_ctrl;
   localparam int MAXC = 600;
   localparam int DRAIN = 7;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [3:0] row_a, col_b, k;
   logic       done, busy, gbuff_a_rd_en, gbuff_b_rd_en, pe_valid, pe_clr, gbuff_out_wr_en;
   logic [7:0] gbuff_a_addr, gbuff_b_addr, gbuff_out_addr;
   logic [1:0] out_sel;
`ifdef CTRL_PERF_CNT_EN
   logic [15:0] perf_cycles;
`endif

   int checks = 0;
   int errors = 0;

   bit         e_rd[MAXC];
   logic [7:0] e_aa[MAXC], e_ba[MAXC], e_wa[MAXC];
   bit         e_v[MAXC], e_clr[MAXC], e_w[MAXC], e_ws[MAXC];
   logic [1:0] e_sel[MAXC];
   int         done_n;

   tpu_ctrl #(.ARRAY_DIM(4), .ADDR_W(8), .DRAIN_CYC(DRAIN)) dut (
      .clk(clk), .rst(rst), .start(start), .row_a(row_a), .col_b(col_b), .k(k),
      .done(done), .busy(busy),
      .gbuff_a_rd_en(gbuff_a_rd_en), .gbuff_a_addr(gbuff_a_addr),
      .gbuff_b_rd_en(gbuff_b_rd_en), .gbuff_b_addr(gbuff_b_addr),
      .pe_valid(pe_valid), .pe_clr(pe_clr), .out_sel(out_sel),
      .gbuff_out_wr_en(gbuff_out_wr_en), .gbuff_out_addr(gbuff_out_addr)
`ifdef CTRL_PERF_CNT_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Cycle n = 0 is the cycle right after start is sampled; tile t occupies a fixed window of P cycles.
   function automatic void build_model(input int r, input int c, input int kk);
      int tr_n, tc_n, p, n0, wbase, t;
      for (int n = 0; n < MAXC; n++) begin
         e_rd[n] = 0; e_v[n] = 0; e_clr[n] = 0; e_w[n] = 0; e_ws[n] = 0;
         e_aa[n] = 0; e_ba[n] = 0; e_wa[n] = 0; e_sel[n] = 0;
      end
      if (r == 0 || c == 0) begin
         done_n = 1;
         return;
      end
      tr_n  = (r + 3) / 4;
      tc_n  = (c + 3) / 4;
      p     = (kk == 0) ? 5 : kk + DRAIN + 1 + 4 + 1;
      wbase = (kk == 0) ? 0 : kk + DRAIN + 1;
      t = 0;
      for (int tc = 0; tc < tc_n; tc++)
         for (int tr = 0; tr < tr_n; tr++) begin
            n0 = 1 + t * p;
            for (int i = 0; i < kk; i++) begin
               e_rd[n0 + i]    = 1;
               e_aa[n0 + i]    = 8'(tr * kk + i);
               e_ba[n0 + i]    = 8'(tc * kk + i);
               e_v[n0 + i + 1] = 1;
            end
            for (int j = 0; j < 4; j++) begin
               e_ws[n0 + wbase + j]  = 1;
               e_sel[n0 + wbase + j] = 2'(j);
               e_w[n0 + wbase + j]   = (4 * tr + j < r);
               e_wa[n0 + wbase + j]  = 8'(tc * r + 4 * tr + j);
            end
            e_clr[n0 + wbase + 4] = 1;
            t++;
         end
      done_n = 1 + t * p;
   endfunction

   // Presents a job, then compares every output each cycle up to `upto` (or done_n+hold when upto<0).
   task automatic run_job(input int r, input int c, input int kk, input bit toggle, input int hold,
                          input int upto, output int writes, output int clrs);
      int last;
      build_model(r, c, kk);
      last = (upto >= 0) ? upto : done_n + hold;
      writes = 0;
      clrs = 0;
      row_a = 4'(r); col_b = 4'(c); k = 4'(kk); start = 1'b1;
      @(posedge clk);
      for (int n = 0; n <= last; n++) begin
         @(negedge clk);
         if (toggle) begin
            row_a = 4'($urandom); col_b = 4'($urandom); k = 4'($urandom);
         end
         writes += int'(gbuff_out_wr_en === 1'b1);
         clrs   += int'(pe_clr === 1'b1);
         checks++;
         if (busy !== (n < done_n) || done !== (n >= done_n)) begin
            errors++;
            $display("FAIL busy/done n=%0d got %b/%b want %b/%b", n, busy, done, n < done_n, n >= done_n);
         end
         checks++;
         if (gbuff_a_rd_en !== e_rd[n] || gbuff_b_rd_en !== e_rd[n]) begin
            errors++;
            $display("FAIL rd_en n=%0d got a=%b b=%b want %b", n, gbuff_a_rd_en, gbuff_b_rd_en, e_rd[n]);
         end
         if (e_rd[n]) begin
            checks++;
            if (gbuff_a_addr !== e_aa[n] || gbuff_b_addr !== e_ba[n]) begin
               errors++;
               $display("FAIL rd_addr n=%0d got a=%0d b=%0d want a=%0d b=%0d", n, gbuff_a_addr,
                        gbuff_b_addr, e_aa[n], e_ba[n]);
            end
         end
         checks++;
         if (pe_valid !== e_v[n] || pe_clr !== e_clr[n]) begin
            errors++;
            $display("FAIL valid/clr n=%0d got %b/%b want %b/%b", n, pe_valid, pe_clr, e_v[n], e_clr[n]);
         end
         checks++;
         if (gbuff_out_wr_en !== e_w[n]) begin
            errors++;
            $display("FAIL wr_en n=%0d got %b want %b", n, gbuff_out_wr_en, e_w[n]);
         end
         if (e_ws[n]) begin
            checks++;
            if (out_sel !== e_sel[n]) begin
               errors++;
               $display("FAIL out_sel n=%0d got %0d want %0d", n, out_sel, e_sel[n]);
            end
         end
         if (e_w[n]) begin
            checks++;
            if (gbuff_out_addr !== e_wa[n]) begin
               errors++;
               $display("FAIL wr_addr n=%0d got %0d want %0d", n, gbuff_out_addr, e_wa[n]);
            end
         end
`ifdef CTRL_PERF_CNT_EN
         if (n >= done_n) begin
            checks++;
            if (perf_cycles !== 16'(done_n - 1)) begin
               errors++;
               $display("FAIL perf_cycles n=%0d got %0d want %0d", n, perf_cycles, done_n - 1);
            end
         end
`endif
      end
      if (upto < 0) begin
         start = 1'b0;
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release got done=%b busy=%b want 0/0", done, busy);
         end
      end
   endtask

   task automatic check_quiet(input string tag);
      checks++;
      if ({done, busy, gbuff_a_rd_en, gbuff_b_rd_en, pe_valid, pe_clr, gbuff_out_wr_en} !== 7'b0 ||
          {gbuff_a_addr, gbuff_b_addr, gbuff_out_addr, out_sel} !== 26'b0) begin
         errors++;
         $display("FAIL %s got ctrl=%b addrs=%h/%h/%h sel=%0d want all 0", tag,
                  {done, busy, gbuff_a_rd_en, gbuff_b_rd_en, pe_valid, pe_clr, gbuff_out_wr_en},
                  gbuff_a_addr, gbuff_b_addr, gbuff_out_addr, out_sel);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; row_a = '0; col_b = '0; k = '0;
      #1 check_quiet("reset_values");
`ifdef CTRL_PERF_CNT_EN
      checks++;
      if (perf_cycles !== 16'd0) begin
         errors++;
         $display("FAIL perf_reset got %0d want 0", perf_cycles);
      end
`endif
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk) check_quiet("idle_after_reset");
   endtask

   task automatic test_single_tile();
      int w, c;
      run_job(4, 4, 4, 1'b0, 3, -1, w, c);
      checks++;
      if (done_n != 18 || w != 4 || c != 1) begin
         errors++;
         $display("FAIL single_tile got done_n=%0d writes=%0d clrs=%0d want 18/4/1", done_n, w, c);
      end
   endtask

   task automatic test_tile_order();
      int w, c;
      run_job(6, 8, 3, 1'b0, 1, -1, w, c);
      checks++;
      if (w != 12 || c != 4) begin
         errors++;
         $display("FAIL tile_order got writes=%0d clrs=%0d want 12/4", w, c);
      end
   endtask

   task automatic test_degenerate();
      int w, c;
      run_job(0, 5, 7, 1'b0, 1, -1, w, c);
      checks++;
      if (w != 0 || c != 0 || done_n != 1) begin
         errors++;
         $display("FAIL r_zero got writes=%0d clrs=%0d want 0/0", w, c);
      end
      run_job(4, 4, 0, 1'b0, 1, -1, w, c);
      checks++;
      if (w != 4 || c != 1) begin
         errors++;
         $display("FAIL k_zero got writes=%0d clrs=%0d want 4/1", w, c);
      end
   endtask

   task automatic test_reset_mid_job();
      int w, c;
      // second tile of an 8x4x4 job begins feeding at n=18
      run_job(8, 4, 4, 1'b0, 0, 19, w, c);
      #2 rst = 1'b1;
      #1 check_quiet("async_reset_mid_feed");
      start = 1'b0;
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk) check_quiet("quiet_after_abort");
      end
      run_job(4, 4, 4, 1'b0, 1, -1, w, c);
      checks++;
      if (w != 4) begin
         errors++;
         $display("FAIL restart_after_reset got writes=%0d want 4", w);
      end
   endtask

   task automatic test_start_hold();
      int w, c;
      run_job(4, 8, 2, 1'b1, 12, -1, w, c);
      run_job(9, 3, 5, 1'b1, 2, -1, w, c);
      checks++;
      if (w != 9 || c != 3) begin
         errors++;
         $display("FAIL new_job_values got writes=%0d clrs=%0d want 9/3", w, c);
      end
   endtask

   task automatic test_random();
      int w, c, r, cc, kk, exp_w;
      for (int i = 0; i < 8; i++) begin
         r  = (i == 7) ? 15 : int'($urandom_range(1, 15));
         cc = (i == 7) ? 15 : int'($urandom_range(1, 15));
         kk = (i == 7) ? 15 : int'($urandom_range(0, 15));
         run_job(r, cc, kk, 1'(i % 2), 1, -1, w, c);
         exp_w = r * ((cc + 3) / 4);
         checks++;
         if (w != exp_w || c != ((r + 3) / 4) * ((cc + 3) / 4)) begin
            errors++;
            $display("FAIL random_job r=%0d c=%0d k=%0d got writes=%0d clrs=%0d want %0d/%0d",
                     r, cc, kk, w, c, exp_w, ((r + 3) / 4) * ((cc + 3) / 4));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_tile();
      test_tile_order();
      test_degenerate();
      test_reset_mid_job();
      test_start_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
